// File: rtl/draw_pkg.sv
// rtl/draw_pkg.sv - shared command codes, screen geometry and colours for the sprite datapath
package draw_pkg;

    // Controller command codes shared with the movement controller
    localparam logic [3:0] PREHOLD = 4'b0100;
    localparam logic [3:0] HOLD    = 4'b0000;
    localparam logic [3:0] CLEAR   = 4'b0001;
    localparam logic [3:0] LEFT    = 4'b0011;
    localparam logic [3:0] RIGHT   = 4'b0010;
    localparam logic [3:0] DOWN    = 4'b0110;
    localparam logic [3:0] UP      = 4'b0111;
    localparam logic [3:0] DRAW    = 4'b0101;
    localparam logic [3:0] SHOT    = 4'b1000;
    localparam logic [3:0] ESCAPED = 4'b1001;
    localparam logic [3:0] IS_SHOT = 4'b1010;

    // Sprite geometry; SIZE must be a power of two so col/row are bit fields of k
    localparam int SIZE  = 4;
    localparam int STEP  = 1;
    localparam int X_MAX = 159;
    localparam int Y_MAX = 119;
    localparam int CR_W  = $clog2(SIZE);
    localparam int K_W   = 2 * CR_W;

    // Highest top-left coordinate that keeps the whole sprite on screen
    localparam logic [7:0] X_LIM = 8'(X_MAX - SIZE + 1);
    localparam logic [6:0] Y_LIM = 7'(Y_MAX - SIZE + 1);

    localparam logic [7:0] P_X0 = 8'd78;
    localparam logic [6:0] P_Y0 = 7'd58;
    localparam logic [7:0] B_X0 = 8'd0;
    localparam logic [6:0] B_Y0 = 7'd0;

    localparam logic [2:0] BG_COLOUR = 3'b011;
    localparam logic [2:0] P_COLOUR  = 3'b111;
    localparam logic [2:0] B_COLOUR  = 3'b100;

    typedef enum logic [1:0] {
        ENG_IDLE,
        ENG_SWEEP,
        ENG_DONE,
        ENG_WAIT
    } eng_state_t;

    // Saturating column step: widened sum so the clamp sees any overflow
    function automatic logic [7:0] step_x(input logic [7:0] pos, input logic inc);
        logic [8:0] sum;
        sum = {1'b0, pos} + 9'(STEP);
        if (inc)
            return (sum > {1'b0, X_LIM}) ? X_LIM : sum[7:0];
        else
            return (pos < 8'(STEP)) ? 8'd0 : pos - 8'(STEP);
    endfunction

    // Saturating row step
    function automatic logic [6:0] step_y(input logic [6:0] pos, input logic inc);
        logic [7:0] sum;
        sum = {1'b0, pos} + 8'(STEP);
        if (inc)
            return (sum > {1'b0, Y_LIM}) ? Y_LIM : sum[6:0];
        else
            return (pos < 7'(STEP)) ? 7'd0 : pos - 7'(STEP);
    endfunction

endpackage

// File: rtl/sprite_sweep.sv
// rtl/sprite_sweep.sv - row-major pixel index counter for one SIZE x SIZE sprite
module sprite_sweep
    import draw_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            en,
    output logic [CR_W-1:0] col,
    output logic [CR_W-1:0] row,
    output logic            last
);

    logic [K_W-1:0] k;

    assign col  = k[CR_W-1:0];
    assign row  = k[K_W-1:CR_W];
    assign last = (k == '1);

    // Advance k while sweeping; wrap to 0 after the last pixel so the next sweep starts clean
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            k <= '0;
        else if (en)
            k <= last ? '0 : k + K_W'(1);
    end

endmodule

// File: rtl/sprite_draw_engine.sv
// rtl/sprite_draw_engine.sv - sprite positions, move handling and VGA sweep sequencing
module sprite_draw_engine
    import draw_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] STATE,
    input  logic       PorB,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       doneDrawing
);

    eng_state_t      eng, eng_next;
    logic            accept, sweep_en;
    logic [CR_W-1:0] col, row;
    logic            last;
    logic [3:0]      start_cmd;
    logic [7:0]      org_x, p_x, b_x;
    logic [6:0]      org_y, p_y, b_y;

    sprite_sweep u_sweep (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (sweep_en),
        .col     (col),
        .row     (row),
        .last    (last)
    );

    // Engine state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            eng <= ENG_IDLE;
        else
            eng <= eng_next;
    end

    // Next state plus accept/sweep strobes
    always_comb begin
        eng_next = eng;
        accept   = 1'b0;
        sweep_en = 1'b0;
        case (eng)
            ENG_IDLE: begin
                if (STATE == CLEAR || STATE == DRAW) begin
                    accept   = 1'b1;
                    eng_next = ENG_SWEEP;
                end
            end
            ENG_SWEEP: begin
                sweep_en = 1'b1;
                if (last)
                    eng_next = ENG_DONE;
            end
            ENG_DONE: eng_next = ENG_WAIT;
            ENG_WAIT: begin
                // Held command must not retrigger; wait for the controller to move on
                if (STATE != start_cmd)
                    eng_next = ENG_IDLE;
            end
            default: eng_next = ENG_IDLE;
        endcase
    end

    // Sweep latches and registered VGA outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x           <= '0;
            y           <= '0;
            colour      <= '0;
            plot        <= 1'b0;
            doneDrawing <= 1'b0;
            start_cmd   <= HOLD;
            org_x       <= '0;
            org_y       <= '0;
        end else begin
            plot        <= 1'b0;
            doneDrawing <= (eng == ENG_DONE);
            if (accept) begin
                start_cmd <= STATE;
                org_x     <= PorB ? b_x : p_x;
                org_y     <= PorB ? b_y : p_y;
                if (STATE == CLEAR)
                    colour <= BG_COLOUR;
                else
                    colour <= PorB ? B_COLOUR : P_COLOUR;
            end
            if (sweep_en) begin
                x    <= org_x + 8'(col);
                y    <= org_y + 7'(row);
                plot <= 1'b1;
            end
        end
    end

    // Move commands act on the currently selected sprite in every engine state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_x <= P_X0;
            p_y <= P_Y0;
            b_x <= B_X0;
            b_y <= B_Y0;
        end else begin
            case (STATE)
                LEFT:  if (PorB) b_x <= step_x(b_x, 1'b0); else p_x <= step_x(p_x, 1'b0);
                RIGHT: if (PorB) b_x <= step_x(b_x, 1'b1); else p_x <= step_x(p_x, 1'b1);
                UP:    if (PorB) b_y <= step_y(b_y, 1'b0); else p_y <= step_y(p_y, 1'b0);
                DOWN:  if (PorB) b_y <= step_y(b_y, 1'b1); else p_y <= step_y(p_y, 1'b1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_draw_engine.sv
// tb/tb_sprite_draw_engine.sv - directed table-driven bench for sprite_draw_engine
module tb_sprite_draw_engine;

    localparam logic [3:0] C_HOLD  = 4'b0000;
    localparam logic [3:0] C_CLEAR = 4'b0001;
    localparam logic [3:0] C_LEFT  = 4'b0011;
    localparam logic [3:0] C_RIGHT = 4'b0010;
    localparam logic [3:0] C_DOWN  = 4'b0110;
    localparam logic [3:0] C_UP    = 4'b0111;
    localparam logic [3:0] C_DRAW  = 4'b0101;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] STATE;
    logic       PorB;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       doneDrawing;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] mv;
        logic       mv_porb;
        int         n;
        logic [3:0] cmd;
        logic       porb;
        logic [2:0] col;
        int         x0;
        int         y0;
    } vec_t;

    vec_t vecs[10];

    sprite_draw_engine dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .STATE       (STATE),
        .PorB        (PorB),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .plot        (plot),
        .doneDrawing (doneDrawing)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pix(input logic p, input logic d, input logic [2:0] c,
                                        input int px, input int py);
        return {12'd0, p, d, c, 8'(px), 7'(py)};
    endfunction

    function automatic logic [31:0] outs();
        return {12'd0, plot, doneDrawing, colour, x, y};
    endfunction

    task automatic do_move(input logic [3:0] mv, input logic p, input int n);
        if (n > 0) begin
            STATE = mv;
            PorB  = p;
            repeat (n) @(negedge clk);
            STATE = C_HOLD;
            @(negedge clk);
        end
    endtask

    // 16 pixels, then exactly one doneDrawing with plot low
    task automatic check_pixels(input string tag, input logic [2:0] c, input int x0, input int y0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check($sformatf("%s pixel %0d", tag, i), outs(), pix(1'b1, 1'b0, c, x0 + i % 4, y0 + i / 4));
        end
        @(negedge clk);
        check({tag, " done"}, {30'd0, plot, doneDrawing}, 32'b01);
    endtask

    // Start a sweep, flip PorB mid-sweep (must be ignored), then hold the command
    task automatic run_sweep(input string tag, input logic [3:0] cmd, input logic p,
                             input logic [2:0] c, input int x0, input int y0);
        STATE = cmd;
        PorB  = p;
        @(negedge clk);
        check({tag, " accept dead"}, {30'd0, plot, doneDrawing}, 32'b00);
        PorB = ~p;
        check_pixels(tag, c, x0, y0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("%s held %0d", tag, i), {30'd0, plot, doneDrawing}, 32'b00);
        end
        STATE = C_HOLD;
        PorB  = p;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{C_HOLD,  1'b0, 0,  C_CLEAR, 1'b0, 3'b011, 78,  58};
        vecs[1] = '{C_RIGHT, 1'b0, 1,  C_DRAW,  1'b0, 3'b111, 79,  58};
        vecs[2] = '{C_LEFT,  1'b1, 3,  C_DRAW,  1'b1, 3'b100, 0,   0};
        vecs[3] = '{C_RIGHT, 1'b0, 76, C_CLEAR, 1'b0, 3'b011, 155, 58};
        vecs[4] = '{C_RIGHT, 1'b0, 5,  C_DRAW,  1'b0, 3'b111, 156, 58};
        vecs[5] = '{C_DOWN,  1'b0, 70, C_DRAW,  1'b0, 3'b111, 156, 116};
        vecs[6] = '{C_DOWN,  1'b1, 5,  C_DRAW,  1'b1, 3'b100, 0,   5};
        vecs[7] = '{C_UP,    1'b1, 10, C_CLEAR, 1'b1, 3'b011, 0,   0};
        vecs[8] = '{C_UP,    1'b0, 3,  C_DRAW,  1'b0, 3'b111, 156, 113};
        vecs[9] = '{C_LEFT,  1'b0, 6,  C_DRAW,  1'b0, 3'b111, 150, 113};

        reset_n = 1'b0;
        STATE   = C_HOLD;
        PorB    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outputs", outs(), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle after reset", outs(), 32'd0);

        for (int v = 0; v < 10; v++) begin
            do_move(vecs[v].mv, vecs[v].mv_porb, vecs[v].n);
            run_sweep($sformatf("vec%0d", v), vecs[v].cmd, vecs[v].porb,
                      vecs[v].col, vecs[v].x0, vecs[v].y0);
        end

        // Back-to-back CLEAR then DRAW: two dead cycles after doneDrawing
        STATE = C_CLEAR;
        PorB  = 1'b0;
        @(negedge clk);
        check("b2b accept dead", {30'd0, plot, doneDrawing}, 32'b00);
        check_pixels("b2b clear", 3'b011, 150, 113);
        STATE = C_DRAW;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("b2b gap %0d", i), {30'd0, plot, doneDrawing}, 32'b00);
        end
        check_pixels("b2b draw", 3'b111, 150, 113);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("b2b held %0d", i), {30'd0, plot, doneDrawing}, 32'b00);
        end
        STATE = C_HOLD;
        repeat (2) @(negedge clk);

        // Reset while k = 7 of a DRAW sweep is on the outputs
        STATE = C_DRAW;
        PorB  = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) @(negedge clk);
        check("pre-reset pixel 7", outs(), pix(1'b1, 1'b0, 3'b111, 153, 114));
        reset_n = 1'b0;
        #1;
        check("async reset outputs", outs(), 32'd0);
        STATE = C_HOLD;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("abandoned sweep %0d", i), {30'd0, plot, doneDrawing}, 32'b00);
        end
        run_sweep("post reset", C_CLEAR, 1'b0, 3'b011, 78, 58);
        run_sweep("post reset bird", C_DRAW, 1'b1, 3'b100, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
